// File: rtl/if_fetch_pkg.sv
// rtl/if_fetch_pkg.sv - shared widths, state encoding and address helper for the fetch stage
package if_fetch_pkg;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;

  localparam logic [DATA_W-1:0] ZERO_WORD = '0;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_REQ  = 2'b01,
    S_HOLD = 2'b10
  } fetch_state_e;

  // Instruction addresses are word aligned; the low two bits never reach memory.
  function automatic logic [ADDR_W-1:0] word_align(input logic [ADDR_W-1:0] addr);
    return addr & ~ADDR_W'(3);
  endfunction

endpackage

// File: rtl/if_fetch_if.sv
// rtl/if_fetch_if.sv - instruction-memory and IF/ID handshake bundle
interface if_fetch_if;
  import if_fetch_pkg::*;

  // instruction memory read port
  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic              imem_ack;
  logic [DATA_W-1:0] imem_rdata;

  // IF/ID boundary
  logic              valid;
  logic              ready;
  logic [ADDR_W-1:0] pc;
  logic [DATA_W-1:0] inst;

  modport master (
    output imem_req, imem_addr, valid, pc, inst,
    input  imem_ack, imem_rdata, ready
  );

  modport slave (
    input  imem_req, imem_addr, valid, pc, inst,
    output imem_ack, imem_rdata, ready
  );

endinterface

// File: rtl/if_fetch_pc_reg.sv
// rtl/if_fetch_pc_reg.sv - program counter with sequential/branch next-pc mux
module if_fetch_pc_reg
  import if_fetch_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              inc_en,
  input  logic [ADDR_W-1:0] inc_base,
  input  logic              br_en,
  input  logic [ADDR_W-1:0] br_target,
  output logic [ADDR_W-1:0] pc_q
);

  logic [ADDR_W-1:0] pc_d;

  // Branch wins over the sequential step; the step wraps modulo 2^ADDR_W.
  always_comb begin
    pc_d = pc_q;
    if (br_en) begin
      pc_d = word_align(br_target);
    end else if (inc_en) begin
      pc_d = inc_base + ADDR_W'(4);
    end
  end

  // Program counter register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

endmodule

// File: rtl/if_fetch.sv
// rtl/if_fetch.sv - instruction-fetch stage: FSM, request latch and IF/ID output registers
module if_fetch
  import if_fetch_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              branch_flag_i,
  input  logic [ADDR_W-1:0] branch_target_i,
  if_fetch_if.master        bus
);

  fetch_state_e      state_q, state_d;
  logic [ADDR_W-1:0] req_addr_q, req_addr_d;
  logic              kill_q, kill_d;
  logic              req_q, req_d;
  logic              valid_q, valid_d;
  logic [ADDR_W-1:0] pc_o_q, pc_o_d;
  logic [DATA_W-1:0] inst_q, inst_d;
  logic [ADDR_W-1:0] pc_q;
  logic [ADDR_W-1:0] target;
  logic              pc_inc;
  logic              pc_br;

  assign target = word_align(branch_target_i);

  if_fetch_pc_reg #(
    .RESET_PC (RESET_PC)
  ) u_pc_reg (
    .clk       (clk),
    .rst       (rst),
    .inc_en    (pc_inc),
    .inc_base  (req_addr_q),
    .br_en     (pc_br),
    .br_target (target),
    .pc_q      (pc_q)
  );

  // Next state, request address latch, kill flag and presented-instruction decisions
  always_comb begin
    state_d    = state_q;
    req_addr_d = req_addr_q;
    kill_d     = kill_q;
    valid_d    = valid_q;
    pc_o_d     = pc_o_q;
    inst_d     = inst_q;
    pc_inc     = 1'b0;
    pc_br      = 1'b0;
    case (state_q)
      S_IDLE: begin
        state_d    = S_REQ;
        req_addr_d = branch_flag_i ? target : pc_q;
        pc_br      = branch_flag_i;
      end
      S_REQ: begin
        if (bus.imem_ack) begin
          if (kill_q || branch_flag_i) begin
            // stale data: drop it and refetch from the redirected pc
            req_addr_d = branch_flag_i ? target : pc_q;
            pc_br      = branch_flag_i;
            kill_d     = 1'b0;
          end else begin
            pc_o_d  = req_addr_q;
            inst_d  = bus.imem_rdata;
            valid_d = 1'b1;
            pc_inc  = 1'b1;
            state_d = S_HOLD;
          end
        end else if (branch_flag_i) begin
          // the request in flight cannot be withdrawn, so mark its data for discard
          pc_br  = 1'b1;
          kill_d = 1'b1;
        end
      end
      S_HOLD: begin
        if (branch_flag_i) begin
          valid_d    = 1'b0;
          pc_br      = 1'b1;
          req_addr_d = target;
          state_d    = S_REQ;
        end else if (bus.ready) begin
          valid_d    = 1'b0;
          req_addr_d = pc_q;
          state_d    = S_REQ;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    req_d = (state_d == S_REQ);
  end

  // FSM state and registered outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      req_addr_q <= RESET_PC;
      kill_q     <= 1'b0;
      req_q      <= 1'b0;
      valid_q    <= 1'b0;
      pc_o_q     <= '0;
      inst_q     <= ZERO_WORD;
    end else begin
      state_q    <= state_d;
      req_addr_q <= req_addr_d;
      kill_q     <= kill_d;
      req_q      <= req_d;
      valid_q    <= valid_d;
      pc_o_q     <= pc_o_d;
      inst_q     <= inst_d;
    end
  end

  assign bus.imem_req  = req_q;
  assign bus.imem_addr = req_addr_q;
  assign bus.valid     = valid_q;
  assign bus.pc        = pc_o_q;
  assign bus.inst      = inst_q;

endmodule
